uart_receiver: RTL and testbench

//  Receive side of the UART: recovers frames from the serial line driven by UART_transmitter.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_rx_data_sampler.sv | 90 +++++++++
 rtl/uart_receiver.sv | 122 ++++++++++++
 tb/tb_uart_receiver.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types: receiver states, parity encodings and the
//               transmitter bit-select constants.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   // Transmitter output-mux selects; both directions share one frame order.
   localparam logic [1:0] TX_SEL_START  = 2'd0;
   localparam logic [1:0] TX_SEL_DATA   = 2'd1;
   localparam logic [1:0] TX_SEL_PARITY = 2'd2;
   localparam logic [1:0] TX_SEL_STOP   = 2'd3;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_data_sampler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_data_sampler
// Description : Line synchroniser, bit-period counters and bit decision.
//               UART_RX_MAJORITY_VOTE_EN selects 2-of-3 voting around the
//               mid-bit point (decision one cycle later).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_data_sampler
   import uart_pkg::*;
#(
   parameter int PRESCALE_WIDTH = 6,
   parameter int BIT_CNT_WIDTH  = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      serial_data_in,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   input  logic                      start,
   input  logic                      active,
   output logic                      rx_s,
   output logic                      sampled_bit,
   output logic                      sample_strobe,
   output logic                      bit_wrap,
   output logic [BIT_CNT_WIDTH-1:0]  bit_cnt
);

   logic                      r_sync1;
   logic                      r_sync2;
   logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
   logic [BIT_CNT_WIDTH-1:0]  r_bit_cnt;
   logic [PRESCALE_WIDTH-1:0] w_sp;

   assign w_sp     = prescale >> 1;
   assign rx_s     = r_sync2;
   assign bit_cnt  = r_bit_cnt;
   assign bit_wrap = active && (r_edge_cnt == prescale - 1'b1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= serial_data_in;
         r_sync2 <= r_sync1;
      end
   end

   // The start-detect cycle is tick 0, so the counter lands on 1 after it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_edge_cnt <= '0;
         r_bit_cnt  <= '0;
      end else if (start) begin
         r_edge_cnt <= {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
         r_bit_cnt  <= '0;
      end else if (!active) begin
         r_edge_cnt <= '0;
         r_bit_cnt  <= '0;
      end else if (bit_wrap) begin
         r_edge_cnt <= '0;
         r_bit_cnt  <= r_bit_cnt + 1'b1;
      end else begin
         r_edge_cnt <= r_edge_cnt + 1'b1;
      end
   end

`ifdef UART_RX_MAJORITY_VOTE_EN
   logic r_s_early;
   logic r_s_mid;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s_early <= 1'b0;
         r_s_mid   <= 1'b0;
      end else if (active) begin
         if (r_edge_cnt == w_sp - 1'b1) r_s_early <= r_sync2;
         if (r_edge_cnt == w_sp)        r_s_mid   <= r_sync2;
      end
   end

   assign sample_strobe = active && (r_edge_cnt == w_sp + 1'b1);
   assign sampled_bit   = majority3(r_s_early, r_s_mid, r_sync2);
`else
   assign sample_strobe = active && (r_edge_cnt == w_sp);
   assign sampled_bit   = r_sync2;
`endif

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : UART receive FSM, shift register, parity check and strobes.
//               Sampling mode follows UART_RX_MAJORITY_VOTE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      parity_enable,
   input  logic                      parity_type,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   input  logic                      serial_data_in,
   output logic [DATA_WIDTH-1:0]     parallel_data,
   output logic                      data_valid,
   output logic                      parity_error,
   output logic                      framing_error
);

   localparam int BIT_CNT_WIDTH = $clog2(DATA_WIDTH + 3);

   rx_state_t                r_state;
   rx_state_t                w_next;
   logic                     w_rx_s;
   logic                     w_bit;
   logic                     w_strobe;
   logic                     w_wrap;
   logic [BIT_CNT_WIDTH-1:0] w_bit_cnt;
   logic                     w_start;
   logic                     w_active;
   logic                     r_par_en;
   logic                     r_par_type;
   logic                     r_par_err;
   logic [DATA_WIDTH-1:0]    r_shift;

   assign w_start  = (r_state == IDLE) && !w_rx_s;
   assign w_active = (r_state != IDLE);

   uart_rx_data_sampler #(
      .PRESCALE_WIDTH (PRESCALE_WIDTH),
      .BIT_CNT_WIDTH  (BIT_CNT_WIDTH)
   ) u_sampler (
      .clk            (clk),
      .reset          (reset),
      .serial_data_in (serial_data_in),
      .prescale       (prescale),
      .start          (w_start),
      .active         (w_active),
      .rx_s           (w_rx_s),
      .sampled_bit    (w_bit),
      .sample_strobe  (w_strobe),
      .bit_wrap       (w_wrap),
      .bit_cnt        (w_bit_cnt)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (!w_rx_s) w_next = START;
         START: begin
            if (w_strobe && w_bit) w_next = IDLE;
            else if (w_wrap)       w_next = DATA;
         end
         DATA: begin
            if (w_wrap && (w_bit_cnt == BIT_CNT_WIDTH'(DATA_WIDTH)))
               w_next = r_par_en ? PARITY : STOP;
         end
         PARITY:  if (w_wrap) w_next = STOP;
         // Leave at the stop decision so a start edge late in the stop bit is caught.
         STOP:    if (w_strobe) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_par_en      <= 1'b0;
         r_par_type    <= PARITY_EVEN;
         r_par_err     <= 1'b0;
         r_shift       <= '0;
         parallel_data <= '0;
         data_valid    <= 1'b0;
         parity_error  <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         data_valid    <= 1'b0;
         parity_error  <= 1'b0;
         framing_error <= 1'b0;
         if (w_start) begin
            r_par_en   <= parity_enable;
            r_par_type <= parity_type;
            r_par_err  <= 1'b0;
         end
         if (w_strobe) begin
            case (r_state)
               DATA:   r_shift   <= {w_bit, r_shift[DATA_WIDTH-1:1]};
               PARITY: r_par_err <= w_bit != ((^r_shift) ^ (r_par_type == PARITY_ODD));
               STOP: begin
                  data_valid    <= w_bit & ~r_par_err;
                  parity_error  <= r_par_err;
                  framing_error <= ~w_bit;
                  if (w_bit && !r_par_err) parallel_data <= r_shift;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_receiver
// Description : Self-checking bench for uart_receiver; frame-level line model
//               with a per-cycle compare of strobes and parallel_data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

   localparam int DW = 8;
   localparam int PW = 6;
`ifdef UART_RX_MAJORITY_VOTE_EN
   localparam int MAJ = 1;
`else
   localparam int MAJ = 0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          parity_enable = 1'b0;
   logic          parity_type = 1'b0;
   logic [PW-1:0] prescale = 6'd8;
   logic          serial_data_in = 1'b1;
   logic [DW-1:0] parallel_data;
   logic          data_valid;
   logic          parity_error;
   logic          framing_error;

   uart_receiver #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
      .clk            (clk),
      .reset          (reset),
      .parity_enable  (parity_enable),
      .parity_type    (parity_type),
      .prescale       (prescale),
      .serial_data_in (serial_data_in),
      .parallel_data  (parallel_data),
      .data_valid     (data_valid),
      .parity_error   (parity_error),
      .framing_error  (framing_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            cyc;
      logic [2:0]    kind;   // {data_valid, parity_error, framing_error}
      logic [DW-1:0] data;
   } ev_t;

   ev_t           evq[$];
   logic          wave[$];
   int            cyc = 0;
   int            n_checks = 0;
   int            n_errors = 0;
   int            dv_cnt = 0, pe_cnt = 0, fe_cnt = 0;
   int            dv0, pe0, fe0;
   logic [DW-1:0] model_data = '0;
   bit            checking = 1'b0;
   logic          prev_reset = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Line level at a cycle offset from the frame's falling edge; idle past the end.
   function automatic logic line_at(input int idx);
      return (idx < wave.size()) ? wave[idx] : 1'b1;
   endfunction

   function automatic logic decide(input int j, input int p);
      int o;
      o = j * p + p / 2;
      if (MAJ != 0)
         return (int'(line_at(o-1)) + int'(line_at(o)) + int'(line_at(o+1))) >= 2;
      return line_at(o);
   endfunction

   // Frame-level decode: returns 1 with the expected strobe (cycle relative to the edge).
   function automatic bit decode(input int p, input bit pen, input bit pty, output ev_t ev);
      logic [DW-1:0] d;
      logic          stop;
      bit            bad;
      ev.cyc  = 0;
      ev.kind = 3'b000;
      ev.data = '0;
      if (decide(0, p)) return 1'b0;
      for (int i = 0; i < DW; i++) d[i] = decide(1 + i, p);
      bad  = pen && (decide(DW + 1, p) != ((^d) ^ pty));
      stop = decide(DW + 1 + int'(pen), p);
      ev.cyc  = 3 + (DW + 1 + int'(pen)) * p + p / 2 + MAJ;
      ev.kind = {stop & ~bad, bad, ~stop};
      ev.data = d;
      return 1'b1;
   endfunction

   task automatic build(input logic [DW-1:0] d, input int p, input bit pen, input bit pty,
                        input bit bad_par, input bit stop_v, input int stop_len, input int gap);
      wave.delete();
      repeat (p) wave.push_back(1'b0);
      for (int i = 0; i < DW; i++) repeat (p) wave.push_back(d[i]);
      if (pen) repeat (p) wave.push_back((^d) ^ pty ^ bad_par);
      repeat (stop_len) wave.push_back(stop_v);
      repeat (gap) wave.push_back(1'b1);
   endtask

   task automatic play(input bit pen, input bit pty);
      ev_t ev;
      bit  has;
      has = decode(int'(prescale), pen, pty, ev);
      for (int i = 0; i < wave.size(); i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            parity_enable = pen;
            parity_type   = pty;
         end
         serial_data_in = wave[i];
         if (i == 0 && has) begin
            ev.cyc += cyc;
            evq.push_back(ev);
         end
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 4000 && evq.size() > 0; i++) @(posedge clk);
      chk("pending_events", evq.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic snap();
      dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
   endtask

   task automatic chk_counts(input string name, input int dv, input int pe, input int fe);
      chk({name, "_dv_count"}, dv_cnt - dv0, dv);
      chk({name, "_pe_count"}, pe_cnt - pe0, pe);
      chk({name, "_fe_count"}, fe_cnt - fe0, fe);
   endtask

   always @(negedge clk) begin
      logic [2:0] exp_k;
      ev_t        ev;
      if (checking) begin
         exp_k = 3'b000;
         if (prev_reset) begin
            model_data = '0;
         end else if (evq.size() > 0 && evq[0].cyc <= cyc) begin
            ev    = evq.pop_front();
            exp_k = ev.kind;
            if (ev.kind[2]) model_data = ev.data;
         end
         chk("strobes_dv_pe_fe", {data_valid, parity_error, framing_error}, exp_k);
         chk("parallel_data", parallel_data, model_data);
         if (data_valid)    dv_cnt++;
         if (parity_error)  pe_cnt++;
         if (framing_error) fe_cnt++;
      end
      prev_reset = reset;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
      $fatal(1, "watchdog");
   end

   initial begin
      ev_t           ev;
      bit            has;
      int            p;
      logic [DW-1:0] d;
      bit            pen, pty, bad, stp;

      repeat (3) @(posedge clk);
      #1 checking = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_parallel_data", parallel_data, 0);
      chk("reset_strobes", {data_valid, parity_error, framing_error}, 0);

      // 1) even parity, 0xA5, correct parity bit 0
      prescale = 6'd8;
      build(8'hA5, 8, 1, 0, 0, 1, 8, 16);
      has = decode(8, 1, 0, ev);
      chk("model_t1_data", ev.data, 8'hA5);
      chk("model_t1_kind", ev.kind, 3'b100);
      chk("model_t1_latency", ev.cyc, 87 + MAJ);
      snap(); play(1, 0); drain();
      chk_counts("t1", 1, 0, 0);
      chk("t1_parallel_data", parallel_data, 8'hA5);

      // 2) odd parity, 0x3C sent with parity bit 0 (wrong)
      build(8'h3C, 8, 1, 1, 1, 1, 8, 16);
      chk("t2_parity_bit_on_line", wave[9*8], 1'b0);
      snap(); play(1, 1); drain();
      chk_counts("t2", 0, 1, 0);
      chk("t2_parallel_data_held", parallel_data, 8'hA5);

      // 3) framing error then a good frame, prescale 16
      prescale = 6'd16;
      snap();
      build(8'h81, 16, 0, 0, 0, 0, 16, 32); play(0, 0);
      build(8'h7E, 16, 0, 0, 0, 1, 16, 32); play(0, 0);
      drain();
      chk_counts("t3", 1, 0, 1);
      chk("t3_parallel_data", parallel_data, 8'h7E);

      // 4) two-cycle low glitch
      prescale = 6'd8;
      wave.delete();
      wave.push_back(1'b0); wave.push_back(1'b0);
      repeat (32) wave.push_back(1'b1);
      snap(); play(0, 0); drain();
      chk_counts("t4", 0, 0, 0);

      // 5) back-to-back with a minimal stop bit, then reset mid-DATA
      snap();
      build(8'h00, 8, 0, 0, 0, 1, 6, 0);  play(0, 0);
      build(8'hFF, 8, 0, 0, 0, 1, 8, 16); play(0, 0);
      drain();
      chk_counts("t5", 2, 0, 0);
      chk("t5_parallel_data", parallel_data, 8'hFF);
      build(8'h55, 8, 0, 0, 0, 1, 8, 16);
      snap();
      for (int i = 0; i < 27; i++) begin
         @(posedge clk); #1 serial_data_in = wave[i];
      end
      @(posedge clk); #1 reset = 1'b1; serial_data_in = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("t5_reset_parallel_data", parallel_data, 0);
      chk("t5_reset_strobes", {data_valid, parity_error, framing_error}, 0);
      repeat (100) @(posedge clk);
      #1;
      chk_counts("t5_reset", 0, 0, 0);

      // 6) one-cycle high glitch at the mid point of data bit 3 of 0x00
      build(8'h00, 8, 0, 0, 0, 1, 8, 16);
      wave[(1 + 3) * 8 + 4] = 1'b1;
      has = decode(8, 0, 0, ev);
      chk("model_t6_data", ev.data, (MAJ != 0) ? 8'h00 : 8'h08);
      snap(); play(0, 0); drain();
      chk_counts("t6", 1, 0, 0);
      chk("t6_parallel_data", parallel_data, (MAJ != 0) ? 8'h00 : 8'h08);

      // Randomised frames: prescale, data, parity setup, occasional bad parity or stop.
      for (int n = 0; n < 40; n++) begin
         p   = 8 + 2 * int'($urandom_range(0, 4));
         d   = DW'($urandom);
         pen = 1'($urandom_range(0, 1));
         pty = 1'($urandom_range(0, 1));
         bad = ($urandom_range(0, 7) == 0);
         stp = ($urandom_range(0, 7) != 0);
         prescale = PW'(p);
         build(d, p, pen, pty, bad, stp, p, 2 * p);
         play(pen, pty);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
